// File: rtl/sum_pkg.sv
// Shared types and constants for the decimal sum entry sequencer.
package sum_pkg;

    // Sequencer states; the encoding doubles as the phase output for display muxing.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER_A = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_ADD     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [3:0]  KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0]  KEY_PLUS      = 4'hA;
    localparam logic [3:0]  KEY_CLEAR     = 4'hB;
    localparam int unsigned BCD_DIGITS    = 3;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal-adjust of the binary sum.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] t;

    // Binary add, then add 6 to skip the six unused codes when the digit overflows.
    always_comb begin
        t = 5'(a) + 5'(b) + 5'(cin);
        if (t > 5'd9) begin
            s    = 4'(t + 5'd6);
            cout = 1'b1;
        end else begin
            s    = t[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/sum_entry_ctrl.sv
// Keypad-driven entry of two 3-digit BCD operands followed by a digit-serial BCD add.
module sum_entry_ctrl
    import sum_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] op_a,
    output logic [11:0] op_b,
    output logic [15:0] sum,
    output logic        sum_valid,
    output logic        busy,
    output logic [2:0]  phase,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    // The counter's next value reaching TIMEOUT_CYC-1 is the expiry condition.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [1:0] DCNT_MAX = 2'(BCD_DIGITS);
    localparam logic [1:0] IDX_LAST = 2'(BCD_DIGITS - 1);

    state_e           state_q, state_d;
    logic [11:0]      op_a_q, op_a_d;
    logic [11:0]      op_b_q, op_b_d;
    logic [15:0]      sum_q, sum_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             sum_valid_q, sum_valid_d;

    logic             is_digit, is_plus, is_clear, is_bad, key_ok;
    logic             in_entry;
    logic [3:0]       add_a, add_b, add_s;
    logic             add_cout;

    assign is_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign is_plus  = key_valid && (key_code == KEY_PLUS);
    assign is_clear = key_valid && (key_code == KEY_CLEAR);
    assign is_bad   = key_valid && (key_code > KEY_CLEAR);
    assign key_ok   = key_valid && !is_bad;
    assign in_entry = (state_q == ST_ENTER_A) || (state_q == ST_ENTER_B);

    // Select the operand digits for the current add index.
    always_comb begin
        add_a = op_a_q[3:0];
        add_b = op_b_q[3:0];
        case (idx_q)
            2'd1: begin
                add_a = op_a_q[7:4];
                add_b = op_b_q[7:4];
            end
            2'd2: begin
                add_a = op_a_q[11:8];
                add_b = op_b_q[11:8];
            end
            default: ;
        endcase
    end

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next-state and datapath update; timeout, invalid keys and CLEAR override the state case.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        tmo_d   = '0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (is_digit) begin
                    state_d = ST_ENTER_A;
                    op_a_d  = {8'h00, key_code};
                    op_b_d  = '0;
                    sum_d   = '0;
                    dcnt_d  = 2'd1;
                end
            end
            ST_ENTER_A: begin
                if (is_digit) begin
                    if (dcnt_q < DCNT_MAX) begin
                        op_a_d = {op_a_q[7:0], key_code};
                        dcnt_d = dcnt_q + 2'd1;
                    end
                end else if (is_plus) begin
                    state_d = ST_ENTER_B;
                    op_b_d  = '0;
                    dcnt_d  = '0;
                end
            end
            ST_ENTER_B: begin
                if (is_digit) begin
                    if (dcnt_q < DCNT_MAX) begin
                        op_b_d = {op_b_q[7:0], key_code};
                        dcnt_d = dcnt_q + 2'd1;
                    end
                end else if (is_plus) begin
                    state_d = ST_ADD;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ST_ADD: begin
                carry_d = add_cout;
                idx_d   = idx_q + 2'd1;
                case (idx_q)
                    2'd0:    sum_d[3:0] = add_s;
                    2'd1:    sum_d[7:4] = add_s;
                    default: sum_d[11:8] = add_s;
                endcase
                if (idx_q == IDX_LAST) begin
                    sum_d[15:12] = {3'b000, add_cout};
                    state_d      = ST_DONE;
                    idx_d        = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inactivity counter only runs while an operand is being typed.
        if (in_entry && !key_ok) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                op_a_d  = '0;
                op_b_d  = '0;
                sum_d   = '0;
                dcnt_d  = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end

        if (is_bad) begin
            err_d = 1'b1;
        end

        if (is_clear) begin
            state_d = ST_IDLE;
            op_a_d  = '0;
            op_b_d  = '0;
            sum_d   = '0;
            dcnt_d  = '0;
            idx_d   = '0;
            carry_d = 1'b0;
            tmo_d   = '0;
            err_d   = 1'b0;
        end
    end

    assign busy_d      = (state_d == ST_ADD);
    assign sum_valid_d = (state_d == ST_DONE);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            dcnt_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            dcnt_q      <= dcnt_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;
    assign phase     = state_q;
    assign err       = err_q;

endmodule
